// File: rtl/onehot_digit_sequencer.sv
// onehot_digit_sequencer: debounced up/down buttons or a prescaled auto-stepper drive a
// 3-bit digit that wraps modulo 8, presented both in binary and one-hot form.
module onehot_digit_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       auto_en,
    input  logic       dir,
    output logic [7:0] onehot,
    output logic [2:0] digit,
    output logic       step_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {MANUAL, AUTO, PAUSE} state_t;

    logic [3:0]    sync1, sync2;
    logic [1:0]    btn_s, deb, accept, press;
    logic [CW-1:0] cnt [2];
    logic          auto_s, dir_s, press_up, press_dn;
    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [2:0]    digit_nxt;
    logic          step_r;

    // synchronizers keep running while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_up, btn_dn, auto_en, dir};
            sync2 <= sync1;
        end
    end

    assign btn_s  = sync2[3:2];
    assign auto_s = sync2[1];
    assign dir_s  = sync2[0];

    always_comb begin
        accept = '0;
        for (int i = 0; i < 2; i++)
            accept[i] = (btn_s[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end

    // press pulses are never held across ena-low cycles, so a frozen press is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '{default: '0};
            deb   <= '0;
            press <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= ena && accept[i] && btn_s[i];
                if (ena) begin
                    if (btn_s[i] == deb[i])
                        cnt[i] <= '0;
                    else if (accept[i]) begin
                        cnt[i] <= '0;
                        deb[i] <= btn_s[i];
                    end else
                        cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press_up = press[1];
    assign press_dn = press[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MANUAL;
            pre    <= '0;
            digit  <= '0;
            step_r <= 1'b0;
        end else begin
            step_r <= ena && (digit_nxt != digit);
            if (ena) begin
                state <= state_nxt;
                pre   <= pre_nxt;
                digit <= digit_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MANUAL:  state_nxt = auto_s ? AUTO : MANUAL;
            AUTO:    state_nxt = !auto_s ? MANUAL : press_up ? PAUSE : AUTO;
            PAUSE:   state_nxt = !auto_s ? MANUAL : press_up ? AUTO : PAUSE;
            default: state_nxt = MANUAL;
        endcase
    end

    always_comb begin
        pre_nxt   = pre;
        digit_nxt = digit;
        case (state)
            MANUAL: begin
                pre_nxt   = '0;
                digit_nxt = (press_up && !press_dn) ? digit + 3'd1 :
                            (press_dn && !press_up) ? digit - 3'd1 : digit;
            end
            AUTO: begin
                if (!auto_s)
                    pre_nxt = '0;
                else if (!press_up) begin
                    pre_nxt   = (pre == PW'(PRESCALE - 1)) ? '0 : pre + PW'(1);
                    digit_nxt = (pre != PW'(PRESCALE - 1)) ? digit :
                                dir_s ? digit + 3'd1 : digit - 3'd1;
                end
            end
            PAUSE:   pre_nxt = auto_s ? pre : '0;
            default: pre_nxt = '0;
        endcase
    end

    assign onehot     = 8'd1 << digit;
    assign step_pulse = step_r && ena;
endmodule

// File: doc/onehot_digit_sequencer.md
ONEHOT_DIGIT_SEQUENCER -- requirements
Module: onehot_digit_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles needed to accept a button level change (legal 2..65535).
REQ-002 SHALL have parameter PRESCALE, default 1000: clock-enable cycles per auto step (legal 2..2^20).
REQ-003 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state except synchronizers.
REQ-006 SHALL have port btn_up  input  1  raw asynchronous pushbutton, active-high.
REQ-007 SHALL have port btn_dn  input  1  raw asynchronous pushbutton, active-high.
REQ-008 SHALL have port auto_en  input  1  raw asynchronous switch; high selects auto-stepping.
REQ-009 SHALL have port dir  input  1  raw asynchronous switch; auto direction, 1 = up, 0 = down.
REQ-010 SHALL have port onehot  output  8  one-hot current digit, bit n set for digit n; feeds the one-hot-to-seven-segment decoder.
REQ-011 SHALL have port digit  output  3  binary current digit 0..7.
REQ-012 SHALL have port step_pulse  output  1  high for one cycle on the cycle after any digit change.

Function
REQ-013 SHALL pass btn_up, btn_dn, auto_en, dir each through a 2-flop synchronizer; synchronizers run regardless of ena.
REQ-014 SHALL debounce btn_up and btn_dn independently: per-button counter clears on any cycle synced level equals debounced level; increments otherwise; when it would reach DEBOUNCE_CYCLES the debounced level takes the synced value and counter clears.
REQ-015 SHALL generate a one-cycle press event on a debounced 0->1 transition only; 1->0 generates nothing.
REQ-016 SHALL treat synced auto_en and dir as level signals without debounce.
REQ-017 SHALL implement FSM states MANUAL, AUTO, PAUSE.
REQ-018 SHALL transition MANUAL->AUTO when synced auto_en=1; AUTO or PAUSE->MANUAL when synced auto_en=0 (priority over button events same cycle).
REQ-019 SHALL in MANUAL: up press alone -> digit+1; dn press alone -> digit-1; both same cycle -> no change.
REQ-020 SHALL in AUTO: prescaler counts 0..PRESCALE-1; at PRESCALE-1 it wraps to 0 and digit steps by dir; up press -> PAUSE; dn press ignored.
REQ-021 SHALL in PAUSE: hold prescaler and digit; up press -> AUTO resuming from held prescaler value; dn press ignored.
REQ-022 SHALL clear prescaler to 0 on every entry to MANUAL and on MANUAL->AUTO.
REQ-023 SHALL wrap digit modulo 8: 7+1 -> 0, 0-1 -> 7.
REQ-024 SHALL register digit; onehot SHALL equal 1<<digit combinationally from the digit register, always exactly one bit set.
REQ-025 SHALL, when ena=0, hold FSM, prescaler, debounce counters, debounced levels, digit; step_pulse forced 0; press events lost, not queued.
REQ-026 SHALL yield button latency: raw edge stable -> digit change at 2 + DEBOUNCE_CYCLES + 1 rising edges; step_pulse high the following cycle.

Reset
REQ-027 SHALL on rst_n=0 asynchronously set digit=0, onehot=8'b00000001, step_pulse=0, FSM=MANUAL, prescaler=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts; reset mid-AUTO or mid-debounce discards all progress.

Verification (bench uses DEBOUNCE_CYCLES=4, PRESCALE=4)
REQ-029 SHALL cover: reset, ena=1, btn_up held 10 cycles -> digit 0->1 at edge 7 after assertion, onehot=8'b00000010, step_pulse one cycle, no second step while held.
REQ-030 SHALL cover: btn_up glitch 3 cycles high then low -> digit stays 0, no step_pulse.
REQ-031 SHALL cover: MANUAL digit=0, clean dn press -> digit=7, onehot=8'b10000000; from 7 an up press -> 0.
REQ-032 SHALL cover: auto_en=1, dir=1 -> digit advances every 4 cycles 0,1,..,7,0; dir=0 -> descends; up press -> PAUSE, digit frozen 20 cycles; second up press -> steps resume with remaining prescale count.
REQ-033 SHALL cover: up and dn debounced presses same cycle in MANUAL -> no change; ena=0 during a press -> no change and step_pulse=0.
REQ-034 SHALL cover: rst_n pulsed low mid-AUTO at digit=5 -> onehot=8'b00000001 immediately (asynchronous), FSM MANUAL until auto_en re-synchronized.
